match_result_serializer: RTL

MATCH_RESULT_SERIALIZER -- requirements
Module: match_result_serializer

---
 rtl/match_result_serializer_pkg.sv | 24 ++
 rtl/match_result_serializer_fifo.sv | 67 ++++++
 rtl/match_result_serializer.sv | 99 +++++++++
 3 files changed

// File: rtl/match_result_serializer_pkg.sv
// Shared definitions for the match result serializer: group mode encodings and lane count.
// Combinational helpers only, so there is no latency.
// No flow control lives here.
package match_result_serializer_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        MODE_ONE  = 2'b00,
        MODE_TWO  = 2'b01,
        MODE_FOUR = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // The reserved mode behaves as a single-entry group.
    function automatic logic [2:0] group_entries(input mode_e mode);
        case (mode)
            MODE_TWO:  group_entries = 3'd2;
            MODE_FOUR: group_entries = 3'd4;
            default:   group_entries = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/match_result_serializer_fifo.sv
// Multi-write FWFT FIFO: writes up to NUM_LANES entries per edge and reads one.
// A write becomes visible at the head in the cycle after the write edge.
// The caller must not write more than the free space allows and must not read when empty.
module result_fifo_mw
    import match_result_serializer_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [2:0]                    wr_cnt,
    input  logic [NUM_LANES-1:0][DW-1:0]  wr_dat,
    input  logic                          rd_en,
    output logic [DW-1:0]                 rd_dat,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] waddr [NUM_LANES];
    logic [AW:0]   wr_add;
    logic [AW:0]   rd_sub;

    // Each lane writes at its own offset, so the pointer wraps naturally inside a group.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            waddr[i] = wr_ptr + i[AW-1:0];
        end
        wr_add = '0;
        if (wr_en) begin
            wr_add[2:0] = wr_cnt;
        end
        rd_sub = {{AW{1'b0}}, rd_en};
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en && (i[2:0] < wr_cnt)) begin
                mem[waddr[i]] <= wr_dat[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + wr_add[AW-1:0];
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level + wr_add - rd_sub;
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/match_result_serializer.sv
// Serializes 1/2/4-entry match result groups into a single stream of (rule, slot) entries.
// When the FIFO is empty, slot0 of an accepted group appears in the cycle after the accepting edge.
// A group that does not fit in the registered free space is dropped whole and counted in drop_cnt.
module match_result_serializer
    import match_result_serializer_pkg::*;
#(
    parameter int BIN_RESULT_WIDTH = 6,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [BIN_RESULT_WIDTH+1:0]   in_result_01,
    input  logic [BIN_RESULT_WIDTH+1:0]   in_result_02,
    input  logic [BIN_RESULT_WIDTH+1:0]   in_result_03,
    input  logic [BIN_RESULT_WIDTH+1:0]   in_result_04,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BIN_RESULT_WIDTH-1:0]   out_rule_id,
    output logic [1:0]                    out_slot,
    output logic                          out_hit,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt
);

    localparam int BW = BIN_RESULT_WIDTH;
    localparam int DW = BW + 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

    mode_e                         grp_mode;
    logic [2:0]                    grp_n;
    logic [AW+1:0]                 need;
    logic                          accept;
    logic                          drop;
    logic                          pop;
    logic [NUM_LANES-1:0][DW-1:0]  wr_dat;
    logic [DW-1:0]                 head;
    logic                          unused_mode_bits;

    assign grp_mode = mode_e'(in_result_01[BW+1:BW]);
    assign grp_n    = group_entries(grp_mode);

    // Only lane 01 carries the group mode.
    assign unused_mode_bits = ^{in_result_02[BW+1:BW], in_result_03[BW+1:BW], in_result_04[BW+1:BW]};

    always_comb begin
        wr_dat    = '0;
        wr_dat[0] = {2'd0, in_result_01[BW-1:0]};
        case (grp_mode)
            MODE_TWO: begin
                wr_dat[1] = {2'd1, in_result_03[BW-1:0]};
            end
            MODE_FOUR: begin
                wr_dat[1] = {2'd1, in_result_02[BW-1:0]};
                wr_dat[2] = {2'd2, in_result_03[BW-1:0]};
                wr_dat[3] = {2'd3, in_result_04[BW-1:0]};
            end
            default: ;
        endcase
    end

    // Free space comes from the registered level; a pop on the same edge earns no credit.
    always_comb begin
        need   = {1'b0, fifo_level} + {{(AW-1){1'b0}}, grp_n};
        accept = in_valid && (need <= DEPTH_W);
        drop   = in_valid && !accept;
    end

    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;

    result_fifo_mw #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (accept),
        .wr_cnt (grp_n),
        .wr_dat (wr_dat),
        .rd_en  (pop),
        .rd_dat (head),
        .level  (fifo_level)
    );

    assign out_rule_id = head[BW-1:0];
    assign out_slot    = head[BW+1:BW];
    assign out_hit     = (out_rule_id != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule
